// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Sequential equivalence checker for pairs of truth tables. On start it
//   snapshots N_FUNC original/simplified table pairs and walks every one of
//   the 2**N_IN input vectors, one per clock. It keeps a per-channel
//   "still equivalent" flag and records the first failing (row, channel).
//
//   Optional build macro: TTC_EARLY_ABORT_EN
//     When defined, the sweep stops at the first row that shows any mismatch.
//     In that case row freezes at the failing row, and eq covers only the
//     rows up to and including it.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begin a sweep (sampled only in IDLE)
//   tab_a     original tables, channel k at [k*ROWS +: ROWS], bit i = f(vector i)
//   tab_b     simplified tables, same packing
//   busy      sweep in progress (RUN)
//   done      one-cycle pulse in the cycle after the last compared row
//   row       input vector currently being compared / last compared
//   eq        bit k = 1 while channel k has matched on every compared row
//   fail      at least one mismatch seen in the current/last sweep
//   fail_row  row of the first mismatch
//   fail_ch   lowest channel mismatching at fail_row
module truth_table_checker #(
  parameter  int N_IN   = 2,
  parameter  int N_FUNC = 5,
  localparam int ROWS   = 2 ** N_IN,
  localparam int CW     = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_FUNC*ROWS-1:0] tab_a,
  input  logic [N_FUNC*ROWS-1:0] tab_b,
  output logic                   busy,
  output logic                   done,
  output logic [N_IN-1:0]        row,
  output logic [N_FUNC-1:0]      eq,
  output logic                   fail,
  output logic [N_IN-1:0]        fail_row,
  output logic [CW-1:0]          fail_ch
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [N_FUNC*ROWS-1:0] snap_a, snap_b;
  logic [N_FUNC-1:0]      mism;
  logic                   any_mism;
  logic                   last_row;
  logic                   accept;

  // Lowest set bit of a channel-mismatch vector.
  function automatic logic [CW-1:0] lowest_ch(input logic [N_FUNC-1:0] m);
    logic [CW-1:0] res;
    res = '0;
    for (int k = N_FUNC - 1; k >= 0; k--) begin
      if (m[k]) res = CW'(k);
    end
    return res;
  endfunction

  assign accept   = (state == IDLE) && start;
  assign last_row = (row == N_IN'(ROWS - 1));

  // Per-channel compare of the snapshotted tables at the current row.
  always_comb begin
    logic [ROWS-1:0] ch_a, ch_b;
    mism = '0;
    ch_a = '0;
    ch_b = '0;
    for (int k = 0; k < N_FUNC; k++) begin
      ch_a    = snap_a[k*ROWS +: ROWS];
      ch_b    = snap_b[k*ROWS +: ROWS];
      mism[k] = ch_a[row] ^ ch_b[row];
    end
  end

  assign any_mism = |mism;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
`ifdef TTC_EARLY_ABORT_EN
        if (last_row || any_mism) state_nxt = DONE;
`else
        if (last_row) state_nxt = DONE;
`endif
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table snapshot: inputs are free to change once the sweep has begun.
  always_ff @(posedge clk) begin
    if (accept) begin
      snap_a <= tab_a;
      snap_b <= tab_b;
    end
  end

  // Row walker and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      eq       <= '1;
      fail     <= 1'b0;
      fail_row <= '0;
      fail_ch  <= '0;
    end else if (accept) begin
      row      <= '0;
      eq       <= '1;
      fail     <= 1'b0;
      fail_row <= '0;
      fail_ch  <= '0;
    end else if (state == RUN) begin
      eq <= eq & ~mism;
      if (!fail && any_mism) begin
        fail     <= 1'b1;
        fail_row <= row;
        fail_ch  <= lowest_ch(mism);
      end
`ifdef TTC_EARLY_ABORT_EN
      if (!last_row && !any_mism) row <= row + N_IN'(1);
`else
      if (!last_row) row <= row + N_IN'(1);
`endif
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default configuration: N_IN=2, N_FUNC=5
  logic        start = 1'b0;
  logic [19:0] tab_a = '0, tab_b = '0;
  logic        busy, done, fail;
  logic [1:0]  row, fail_row;
  logic [4:0]  eq;
  logic [2:0]  fail_ch;

  // Small configuration: N_IN=3, N_FUNC=1
  logic        start2 = 1'b0;
  logic [7:0]  tab_a2 = '0, tab_b2 = '0;
  logic        busy2, done2, fail2;
  logic [2:0]  row2, fail_row2;
  logic [0:0]  eq2, fail_ch2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.N_IN(2), .N_FUNC(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tab_a(tab_a), .tab_b(tab_b),
    .busy(busy), .done(done), .row(row), .eq(eq), .fail(fail),
    .fail_row(fail_row), .fail_ch(fail_ch)
  );

  truth_table_checker #(.N_IN(3), .N_FUNC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .tab_a(tab_a2), .tab_b(tab_b2),
    .busy(busy2), .done(done2), .row(row2), .eq(eq2), .fail(fail2),
    .fail_row(fail_row2), .fail_ch(fail_ch2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: walk rows in order, compare every channel's bit,
  // clear eq on any difference, remember the first failing row/channel.
  // In the early-abort build the walk stops after the first failing row.
  typedef struct {
    logic [4:0] eq;
    logic       fail;
    int         frow;
    int         fch;
    int         last;   // final value of row
  } res_t;

  function automatic res_t model(input logic [19:0] a, input logic [19:0] b);
    res_t r;
    r.eq = '1; r.fail = 1'b0; r.frow = 0; r.fch = 0; r.last = 3;
    for (int rw = 0; rw < 4; rw++) begin
      for (int k = 0; k < 5; k++) begin
        if (a[k*4 + rw] != b[k*4 + rw]) begin
          r.eq[k] = 1'b0;
          if (!r.fail) begin
            r.fail = 1'b1;
            r.frow = rw;
            r.fch  = k;
          end
        end
      end
`ifdef TTC_EARLY_ABORT_EN
      if (r.fail) begin
        r.last = rw;
        break;
      end
`endif
    end
    return r;
  endfunction

  // One complete sweep on the default instance. With disturb set, the
  // tables are scrambled and start is re-asserted while RUN is in progress.
  task automatic sweep(input string tag, input logic [19:0] a, input logic [19:0] b,
                       input bit disturb);
    res_t m;
    int   cyc;
    m = model(a, b);
    @(negedge clk);
    tab_a = a; tab_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_row_walk"}, row, cyc - 1);
      if (disturb && cyc == 1) begin
        tab_a = 20'($urandom); tab_b = 20'($urandom); start = 1'b1;
      end
      if (disturb && cyc == 2) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, m.last + 2);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_eq"}, eq, m.eq);
    chk({tag, "_fail"}, fail, m.fail);
    chk({tag, "_fail_row"}, fail_row, m.frow);
    chk({tag, "_fail_ch"}, fail_ch, m.fch);
    chk({tag, "_row_end"}, row, m.last);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_done_single"}, done, 0);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_hold_eq"}, eq, m.eq);
      chk({tag, "_hold_fail_row"}, fail_row, m.frow);
    end
  endtask

  initial begin
    int cyc;
    logic [19:0] ra, rb;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_row", row, 0);
    chk("rst_eq", eq, 5'b11111);
    chk("rst_fail", fail, 0);
    chk("rst_fail_row", fail_row, 0);
    chk("rst_fail_ch", fail_ch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Equivalent set
    sweep("equiv", 20'h0D9D2, 20'h0D9D2, 1'b0);
    chk("equiv_eq_const", eq, 5'b11111);
    chk("equiv_fail_const", fail, 0);

    // Channel c simplified wrongly
    sweep("ch2_bad", 20'h0D9D2, 20'h0DAD2, 1'b0);
    chk("ch2_eq_const", eq, 5'b11011);
    chk("ch2_fail_ch_const", fail_ch, 2);
    chk("ch2_fail_row_const", fail_row, 0);

    // Two channels wrong on the same row
    sweep("multi", 20'h0D9D2, 20'h0C9C2, 1'b0);
    chk("multi_eq_const", eq, 5'b10101);
    chk("multi_fail_ch_const", fail_ch, 1);

    // Mismatch only on the last row
    sweep("lastrow", 20'h0D9D2, 20'h8D9D2, 1'b0);
    chk("lastrow_fail_row_const", fail_row, 3);
    chk("lastrow_fail_ch_const", fail_ch, 4);

    // Inputs disturbed mid-sweep and start re-pulsed during RUN
    sweep("disturb_pass", 20'h0D9D2, 20'h0D9D2, 1'b1);
    sweep("disturb_fail", 20'h0D9D2, 20'h0D9F2, 1'b1);

    // Randomized sweeps against the model
    for (int i = 0; i < 8; i++) begin
      ra = 20'($urandom);
      rb = ra ^ (20'($urandom) & 20'($urandom) & 20'($urandom) & ((i % 3 == 0) ? 20'h0 : 20'hFFFFF));
      sweep("rand", ra, rb, bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a sweep
    @(negedge clk);
    tab_a = 20'h0D9D2; tab_b = 20'h0D9D3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_fail_before", fail, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_eq", eq, 5'b11111);
    chk("midrst_fail", fail, 0);
    chk("midrst_row", row, 0);
    chk("midrst_fail_row", fail_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("after_rst", 20'h0D9D2, 20'h0D9D2, 1'b0);

    // N_IN=3, N_FUNC=1 instance: 0xE8 vs 0xE9 differ only at row 0
    @(negedge clk);
    tab_a2 = 8'hE8; tab_b2 = 8'hE9; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (done2 !== 1'b1 && cyc < 40) begin
      chk("n3_busy", busy2, 1);
      chk("n3_row_walk", row2, cyc - 1);
      @(negedge clk);
      cyc++;
    end
`ifdef TTC_EARLY_ABORT_EN
    chk("n3_done_cycle", cyc, 2);
    chk("n3_row_end", row2, 0);
`else
    chk("n3_done_cycle", cyc, 9);
    chk("n3_row_end", row2, 7);
`endif
    chk("n3_done", done2, 1);
    chk("n3_eq", eq2, 0);
    chk("n3_fail", fail2, 1);
    chk("n3_fail_row", fail_row2, 0);
    chk("n3_fail_ch", fail_ch2, 0);
    @(negedge clk);
    chk("n3_done_drop", done2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
